// File: rtl/i2s_line_in.sv
// I2S master receiver for the codec ADC path: derives mclk/sclk/lrclk from clk,
// captures 16-bit stereo pairs and tracks a windowed 4-bit peak level.
module i2s_line_in #(
  parameter int DATA_W      = 16,
  parameter int PEAK_FRAMES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              audio_sdout,
  output logic              audio_mclk,
  output logic              audio_lrclk,
  output logic              audio_sclk,
  output logic [DATA_W-1:0] left_sample,
  output logic [DATA_W-1:0] right_sample,
  output logic              sample_valid,
  output logic [3:0]        level
);

  localparam int         MAG_W     = DATA_W - 1;
  localparam int         FC_W      = $clog2(PEAK_FRAMES);
  localparam logic [4:0] LAST_SLOT = 5'(DATA_W);

  logic [9:0]        cnt;
  logic [4:0]        slot;
  logic              cap_edge;
  logic              in_data;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] left_hold;
  logic              word_done;
  logic              word_right;

  logic [MAG_W-1:0]  mag_l;
  logic [MAG_W-1:0]  mag_r;
  logic [MAG_W-1:0]  mag_max;
  logic [MAG_W-1:0]  peak_run;
  logic [MAG_W-1:0]  peak_next;
  logic [FC_W-1:0]   frame_cnt;

  // All three codec clocks are plain bits of the registered timebase.
  assign audio_mclk  = cnt[1];
  assign audio_sclk  = cnt[3];
  assign audio_lrclk = cnt[9];

  assign slot     = cnt[8:4];
  assign cap_edge = (cnt[3:0] == 4'd7);
  assign in_data  = (slot != 5'd0) && (slot <= LAST_SLOT);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt          <= '0;
      shreg        <= '0;
      left_hold    <= '0;
      word_done    <= 1'b0;
      word_right   <= 1'b0;
      left_sample  <= '0;
      right_sample <= '0;
      sample_valid <= 1'b0;
    end else begin
      cnt <= cnt + 10'd1;
      // Shift only inside data slots; slot 0 and trailing slots leave it held.
      if (cap_edge && in_data)
        shreg <= {shreg[DATA_W-2:0], audio_sdout};
      word_done  <= cap_edge && (slot == LAST_SLOT);
      word_right <= cnt[9];
      if (word_done && !word_right)
        left_hold <= shreg;
      sample_valid <= word_done && word_right;
      if (word_done && word_right) begin
        left_sample  <= left_hold;
        right_sample <= shreg;
      end
    end
  end

  // |x| in DATA_W-1 bits; the most negative code saturates to all ones.
  function automatic logic [MAG_W-1:0] magnitude(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] neg;
    neg = -x;
    if (!x[DATA_W-1])
      return x[MAG_W-1:0];
    else if (neg[DATA_W-1])
      return '1;
    else
      return neg[MAG_W-1:0];
  endfunction

  // NOTE: every combinational output gets a value on every path, so no latch.
  always_comb begin
    mag_l     = magnitude(left_sample);
    mag_r     = magnitude(right_sample);
    mag_max   = (mag_l > mag_r) ? mag_l : mag_r;
    peak_next = (mag_max > peak_run) ? mag_max : peak_run;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      peak_run  <= '0;
      frame_cnt <= '0;
      level     <= 4'd0;
    end else if (sample_valid) begin
      if (frame_cnt == FC_W'(PEAK_FRAMES - 1)) begin
        level     <= peak_next[MAG_W-1 -: 4];
        peak_run  <= '0;
        frame_cnt <= '0;
      end else begin
        peak_run  <= peak_next;
        frame_cnt <= frame_cnt + FC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_i2s_line_in.sv
// Self-checking bench for i2s_line_in: codec model driven from an independent
// frame counter, scoreboard of expected pairs/levels, table plus random frames.
module tb_i2s_line_in;

  localparam int DW = 16;
  localparam int PF = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          audio_sdout;
  logic          audio_mclk;
  logic          audio_lrclk;
  logic          audio_sclk;
  logic [DW-1:0] left_sample;
  logic [DW-1:0] right_sample;
  logic          sample_valid;
  logic [3:0]    level;

  always #5 clk = ~clk;

  i2s_line_in #(.DATA_W(DW), .PEAK_FRAMES(PF)) dut (
    .clk          (clk),
    .rst          (rst),
    .audio_sdout  (audio_sdout),
    .audio_mclk   (audio_mclk),
    .audio_lrclk  (audio_lrclk),
    .audio_sclk   (audio_sclk),
    .left_sample  (left_sample),
    .right_sample (right_sample),
    .sample_valid (sample_valid),
    .level        (level)
  );

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic        fill;
    bit          use_tbl;
    logic [3:0]  lvl;
  } frame_t;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [3:0]  lvl;
  } exp_t;

  frame_t      tx_q[$];
  exp_t        sb_q[$];
  frame_t      tbl[16];
  int          n_checks = 0;
  int          n_err = 0;
  logic [9:0]  tb_cnt;
  logic [15:0] cur_l, cur_r;
  logic        cur_fill;
  int          m_peak, m_fc;
  logic [3:0]  m_lvl, lvl_pending;
  logic [15:0] prev_l, prev_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t tb_cnt=%0d)", name, act, exp, $time, tb_cnt);
    end
  endtask

  function automatic int mag16(input logic [15:0] x);
    int v;
    v = int'($signed(x));
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  function automatic frame_t mk(input logic [15:0] l, input logic [15:0] r,
                                input logic fill, input logic [3:0] lvl);
    frame_t f;
    f.l = l; f.r = r; f.fill = fill; f.use_tbl = 1'b1; f.lvl = lvl;
    return f;
  endfunction

  task automatic model_reset();
    m_peak = 0;
    m_fc   = 0;
    m_lvl  = 4'd0;
  endtask

  task automatic load_frame();
    frame_t f;
    exp_t   e;
    int     m;
    if (tx_q.size() > 0) f = tx_q.pop_front();
    else begin
      f.l = 16'h0; f.r = 16'h0; f.fill = 1'b0; f.use_tbl = 1'b0; f.lvl = 4'd0;
    end
    m = (mag16(f.l) > mag16(f.r)) ? mag16(f.l) : mag16(f.r);
    if (m > m_peak) m_peak = m;
    m_fc++;
    if (m_fc == PF) begin
      m_lvl  = 4'(m_peak >> 11);
      m_peak = 0;
      m_fc   = 0;
    end
    cur_l    = f.l;
    cur_r    = f.r;
    cur_fill = f.fill;
    e.l   = f.l;
    e.r   = f.r;
    e.lvl = f.use_tbl ? f.lvl : m_lvl;
    sb_q.push_back(e);
  endtask

  function automatic logic bit_for(input logic [9:0] c);
    int          slot;
    logic [15:0] w;
    slot = int'(c[8:4]);
    w    = c[9] ? cur_r : cur_l;
    if (slot >= 1 && slot <= DW) return w[DW-slot];
    return cur_fill;
  endfunction

  task automatic check_outputs();
    exp_t e;
    check("mclk", 32'(audio_mclk), 32'(tb_cnt[1]));
    check("sclk", 32'(audio_sclk), 32'(tb_cnt[3]));
    check("lrclk", 32'(audio_lrclk), 32'(tb_cnt[9]));
    if (tb_cnt == 10'd777) begin
      check("valid_at_777", 32'(sample_valid), 32'd1);
      if (sb_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL scoreboard: no expected pair queued at tb_cnt=777");
      end else begin
        e = sb_q.pop_front();
        check("left_sample", 32'(left_sample), 32'(e.l));
        check("right_sample", 32'(right_sample), 32'(e.r));
        lvl_pending = e.lvl;
      end
    end else begin
      check("valid_idle", 32'(sample_valid), 32'd0);
      check("left_stable", 32'(left_sample), 32'(prev_l));
      check("right_stable", 32'(right_sample), 32'(prev_r));
    end
    if (tb_cnt == 10'd778)
      check("level", 32'(level), 32'(lvl_pending));
    prev_l = left_sample;
    prev_r = right_sample;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    tb_cnt = tb_cnt + 10'd1;
    if (tb_cnt == 10'd0) load_frame();
    audio_sdout = bit_for(tb_cnt);
    check_outputs();
  endtask

  // Asserts reset between clock edges, checks the asynchronous clear, holds it
  // for n edges, then restarts the codec model aligned to cnt = 0.
  task automatic do_reset(input int n);
    rst = 1'b0;
    #1;
    check("rst_left", 32'(left_sample), 32'd0);
    check("rst_right", 32'(right_sample), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_mclk", 32'(audio_mclk), 32'd0);
    check("rst_sclk", 32'(audio_sclk), 32'd0);
    check("rst_lrclk", 32'(audio_lrclk), 32'd0);
    repeat (n) @(posedge clk);
    #1;
    check("rst_held_valid", 32'(sample_valid), 32'd0);
    sb_q.delete();
    model_reset();
    tb_cnt      = 10'd0;
    prev_l      = 16'h0;
    prev_r      = 16'h0;
    lvl_pending = 4'd0;
    load_frame();
    audio_sdout = bit_for(tb_cnt);
    rst = 1'b1;
  endtask

  initial begin
    frame_t f;
    rst         = 1'b0;
    audio_sdout = 1'b0;
    tb_cnt      = 10'd0;
    cur_l       = 16'h0;
    cur_r       = 16'h0;
    cur_fill    = 1'b0;
    model_reset();

    // Window 1..3 of the level test, then ignored-slot and single-pair frames.
    tbl[0]  = mk(16'h1234, 16'hABCD, 1'b0, 4'd0);
    tbl[1]  = mk(16'h1234, 16'hABCD, 1'b0, 4'd0);
    tbl[2]  = mk(16'h1234, 16'hABCD, 1'b0, 4'd0);
    tbl[3]  = mk(16'h1234, 16'hABCD, 1'b0, 4'd10);
    tbl[4]  = mk(16'h8000, 16'h0000, 1'b0, 4'd10);
    tbl[5]  = mk(16'h8000, 16'h0000, 1'b0, 4'd10);
    tbl[6]  = mk(16'h8000, 16'h0000, 1'b0, 4'd10);
    tbl[7]  = mk(16'h8000, 16'h0000, 1'b0, 4'd15);
    tbl[8]  = mk(16'h0000, 16'h0000, 1'b0, 4'd15);
    tbl[9]  = mk(16'h0000, 16'h0000, 1'b0, 4'd15);
    tbl[10] = mk(16'h0000, 16'h0000, 1'b0, 4'd15);
    tbl[11] = mk(16'h0000, 16'h0000, 1'b0, 4'd0);
    tbl[12] = mk(16'h0000, 16'h0001, 1'b1, 4'd0);
    tbl[13] = mk(16'h0000, 16'h0001, 1'b1, 4'd0);
    tbl[14] = mk(16'h1234, 16'hABCD, 1'b1, 4'd0);
    tbl[15] = mk(16'h1234, 16'hABCD, 1'b0, 4'd10);
    for (int i = 0; i < 16; i++) tx_q.push_back(tbl[i]);

    @(posedge clk);
    #1;
    do_reset(3);
    repeat (16 * 1024) tick();

    // Interrupt the idle frame during its right word.
    repeat (700) tick();
    check("pre_reset_left", 32'(left_sample), 32'h1234);
    f.l = 16'h5A5A; f.r = 16'hC3C3; f.fill = 1'b1; f.use_tbl = 1'b0; f.lvl = 4'd0;
    tx_q.push_back(f);
    do_reset(20);
    repeat (1024) tick();

    // Back-to-back random frames, with ignored slots carrying random filler.
    for (int i = 0; i < 40; i++) begin
      f.l       = 16'($urandom);
      f.r       = 16'($urandom);
      if (i % 9 == 4) f.l = 16'h8000;
      f.fill    = 1'($urandom_range(0, 1));
      f.use_tbl = 1'b0;
      f.lvl     = 4'd0;
      tx_q.push_back(f);
    end
    repeat (41 * 1024) tick();
    check("tx_drained", 32'(tx_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
